mem_unit_tip: RTL and testbench
===============================

// Module: mem_unit_tip
// PURPOSE
// Parametrised next-generation memory unit: word-addressed data RAM plus Tightly Integrated Peripheral (TIP) registers.
// Adds NUM_IND indirect pointer channels with optional post-increment, a sticky IRQ pending latch and an external peribus port.
// Sits between the CPU datapath (addr/in_data/out_data, status bits) and the peribus controller. All state is on the rising clock edge.
// PARAMETERS
// DATA_W     16      data word width
// ADDR_W     11      word address width
// MEM_WORDS  512     RAM depth; power of 2; words 0..MEM_WORDS-1
// TIP_BASE   'h200   base address of the TIP register window
// NUM_IND    2       indirect channels, 1..8
// PERI_BASE  'h300   peribus window base
// PERI_SPAN  'h100   peribus window size in words (max 256)
// BAD_VALUE  'hDEAD  read value for unmapped addresses
// PORTS
// clk           in   1       clock
// reset_bar     in   1       asynchronous reset, active low
// addr          in   ADDR_W  word address
// in_data       in   DATA_W  write data
// write_enable  in   1       write strobe; sampled on rising edge
// read_enable   in   1       read strobe; gates side effects only
// wreg          in   DATA_W  CPU working register, read-only mirror
// carry_in      in   1       ALU carry
// zero_in       in   1       ALU zero
// carry_out     out  1       carry status register
// zero_out      out  1       zero status register
// out_data      out  DATA_W  registered read data
// interrupt     out  1       irq_en & irq_pend
// peri_addr     out  8       addr - PERI_BASE (low 8 bits)
// peri_wdata    out  DATA_W  = in_data
// peri_rdata    in   DATA_W  peripheral read data (combinational)
// peri_we       out  1       write_enable & addr in peri window (combinational)
// peri_re       out  1       read_enable & addr in peri window (combinational)
// peri_irq      in   1       peripheral interrupt request (level)
// BEHAVIOUR
// Reset (async, reset_bar=0):
//   - out_data, carry_out, zero_out, irq_en, irq_pend, all pointers, all inc_mode bits = 0.
//   - RAM contents are not cleared.
// Map (offsets from TIP_BASE):
//   - +0 wreg (RO)
//   - +1 carry (bit0)
//   - +2 zero (bit0)
//   - +3 IRQ: bit0 peri_irq (RO), bit1 irq_en (RW), bit2 irq_pend (W1C)
//   - +4+2k IND_V[k]: indirect data
//   - +5+2k IND_A[k]: pointer
//   - +4+2*NUM_IND INC_MODE: bit k enables post-increment for channel k
//   - All other addresses are unmapped.
// Read: every rising edge out_data <= value at addr (1-cycle latency, independent of read_enable).
//   - Unmapped reads return BAD_VALUE.
//   - Reading the IRQ register returns {..,pend,en,peri_irq}.
// Write (write_enable at rising edge):
//   - RAM: write in_data.
//   - carry/zero: take in_data[0] and override carry_in/zero_in that cycle.
//   - wreg: write ignored.
//   - Unmapped addresses: write ignored.
// Status: when not written, carry_out <= carry_in and zero_out <= zero_in each edge.
// Pointers:
//   - A write to IND_A stores in_data & (MEM_WORDS-1), so a pointer can never address a TIP.
//   - IND_V read returns RAM[ptr]; IND_V write updates RAM[ptr].
// Post-increment (INC_MODE bit k = 1):
//   - ptr increments once per edge where IND_V[k] is accessed with read_enable or write_enable high; both high = one increment.
//   - Wraps from MEM_WORDS-1 to 0.
//   - A simultaneous write to IND_A[k] cannot coincide (different address).
// Read-before-write: same-edge read and write of the same RAM word returns the old data.
// Two channels pointing at the same word see a coherent RAM (no shadow copies).
// IRQ:
//   - irq_pend sets on a peri_irq rising edge (registered previous value).
//   - Write with in_data[2]=1 clears irq_pend; set wins over a simultaneous clear.
//   - interrupt is combinational from the irq_en/irq_pend registers.
// Peribus: out_data <= peri_rdata when addr is in the window.
//   - peri_we/peri_re are 0 outside the window; the peripheral samples writes on the same rising edge.
// TESTING
// Write 'h1234 to RAM 'h010, then read 'h010 -> out_data='h1234 one edge later; read 'h2FF -> 'hDEAD.
// IND_A[0]='h1FF, INC_MODE=1, three IND_V[0] writes A,B,C -> RAM['h1FF]=A, RAM[0]=B, RAM[1]=C, ptr=2.
// IND_A[0]=5, mode 0, hold addr=IND_V[0] four cycles with read_enable=1 -> same RAM[5] each cycle, ptr stays 5.
// IND_A write 'hFFFF -> readback 'h1FF; carry write 1 while carry_in=0 -> carry_out=1 next edge.
// irq_en=1, pulse peri_irq -> interrupt=1 after the pulse drops; W1C on the same edge as a new rise -> stays 1.
// Assert reset_bar mid IND_V burst -> out_data=0 and ptrs=0 immediately; RAM data written before reset is intact.

Source files
------------

// File: rtl/mem_unit_tip.sv
// mem_unit_tip: word RAM plus TIP status/IRQ/indirect-pointer registers and a peribus window
module mem_unit_tip #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 11,
  parameter int MEM_WORDS = 512,
  parameter int TIP_BASE  = 'h200,
  parameter int NUM_IND   = 2,
  parameter int PERI_BASE = 'h300,
  parameter int PERI_SPAN = 'h100,
  parameter logic [DATA_W-1:0] BAD_VALUE = 'hDEAD
) (
  input  logic              clk,
  input  logic              reset_bar,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              write_enable,
  input  logic              read_enable,
  input  logic [DATA_W-1:0] wreg,
  input  logic              carry_in,
  input  logic              zero_in,
  output logic              carry_out,
  output logic              zero_out,
  output logic [DATA_W-1:0] out_data,
  output logic              interrupt,
  output logic [7:0]        peri_addr,
  output logic [DATA_W-1:0] peri_wdata,
  input  logic [DATA_W-1:0] peri_rdata,
  output logic              peri_we,
  output logic              peri_re,
  input  logic              peri_irq
);
  localparam int PW = $clog2(MEM_WORDS);
  localparam int MODE_OFF = 4 + 2 * NUM_IND;
  typedef logic [ADDR_W:0] a_t;
  localparam a_t RAM_END = a_t'(MEM_WORDS);
  localparam a_t TIP_LO = a_t'(TIP_BASE);
  localparam a_t TIP_HI = a_t'(TIP_BASE + MODE_OFF + 1);
  localparam a_t PERI_LO = a_t'(PERI_BASE);
  localparam a_t PERI_HI = a_t'(PERI_BASE + PERI_SPAN);
  localparam logic [7:0] PERI_LO8 = 8'(PERI_BASE);

  logic [DATA_W-1:0] r_mem [MEM_WORDS];
  logic [PW-1:0]     r_ptr [NUM_IND];
  logic [NUM_IND-1:0] r_mode;
  logic [DATA_W-1:0] r_out;
  logic r_carry, r_zero, r_en, r_pend, r_irq_prev;
  a_t w_a, w_off;
  logic w_in_ram, w_in_tip, w_in_peri, w_we_ram, w_irq_hit, w_mode_hit, w_clr, w_rise;
  logic [NUM_IND-1:0] w_v_hit, w_p_hit;
  logic [PW-1:0] w_waddr;
  logic [DATA_W-1:0] w_rdata;

  assign w_a = {1'b0, addr};
  assign w_off = w_a - TIP_LO;
  assign w_in_ram = w_a < RAM_END;
  assign w_in_tip = w_a >= TIP_LO && w_a < TIP_HI;
  assign w_in_peri = w_a >= PERI_LO && w_a < PERI_HI;
  assign w_irq_hit = w_in_tip && w_off == a_t'(3);
  assign w_mode_hit = w_in_tip && w_off == a_t'(MODE_OFF);
  assign w_clr = write_enable && w_irq_hit && in_data[2];
  assign w_rise = peri_irq && !r_irq_prev;
  assign w_we_ram = write_enable && (w_in_ram || |w_v_hit);

  // an IND_V access redirects the single RAM port to that channel's pointer
  always_comb begin
    w_v_hit = '0;
    w_p_hit = '0;
    w_waddr = addr[PW-1:0];
    for (int k = 0; k < NUM_IND; k++) begin
      w_v_hit[k] = w_in_tip && w_off == a_t'(4 + 2 * k);
      w_p_hit[k] = w_in_tip && w_off == a_t'(5 + 2 * k);
      if (w_v_hit[k]) w_waddr = r_ptr[k];
    end
  end

  always_comb begin
    w_rdata = BAD_VALUE;
    if (w_in_ram) w_rdata = r_mem[addr[PW-1:0]];
    else if (w_in_peri) w_rdata = peri_rdata;
    else if (w_in_tip) begin
      w_rdata = w_off == a_t'(0) ? wreg :
                w_off == a_t'(1) ? DATA_W'(r_carry) :
                w_off == a_t'(2) ? DATA_W'(r_zero) :
                w_off == a_t'(3) ? DATA_W'({r_pend, r_en, peri_irq}) : DATA_W'(r_mode);
      for (int k = 0; k < NUM_IND; k++) begin
        if (w_v_hit[k]) w_rdata = r_mem[r_ptr[k]];
        if (w_p_hit[k]) w_rdata = DATA_W'(r_ptr[k]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_bar)
    if (!reset_bar) begin
      r_out <= '0;
      r_carry <= 1'b0;
      r_zero <= 1'b0;
      r_en <= 1'b0;
      r_pend <= 1'b0;
      r_irq_prev <= 1'b0;
      r_mode <= '0;
      for (int k = 0; k < NUM_IND; k++) r_ptr[k] <= '0;
    end else begin
      r_out <= w_rdata;
      r_carry <= (write_enable && w_in_tip && w_off == a_t'(1)) ? in_data[0] : carry_in;
      r_zero <= (write_enable && w_in_tip && w_off == a_t'(2)) ? in_data[0] : zero_in;
      r_irq_prev <= peri_irq;
      r_pend <= w_rise || (r_pend && !w_clr);
      if (write_enable && w_irq_hit) r_en <= in_data[1];
      if (write_enable && w_mode_hit) r_mode <= in_data[NUM_IND-1:0];
      for (int k = 0; k < NUM_IND; k++)
        if (write_enable && w_p_hit[k]) r_ptr[k] <= in_data[PW-1:0];
        else if (r_mode[k] && w_v_hit[k] && (read_enable || write_enable)) r_ptr[k] <= r_ptr[k] + PW'(1);
    end

  always_ff @(posedge clk)
    if (w_we_ram) r_mem[w_waddr] <= in_data;

  assign out_data = r_out;
  assign carry_out = r_carry;
  assign zero_out = r_zero;
  assign interrupt = r_en && r_pend;
  assign peri_addr = addr[7:0] - PERI_LO8;
  assign peri_wdata = in_data;
  assign peri_we = write_enable && w_in_peri;
  assign peri_re = read_enable && w_in_peri;
endmodule

// File: tb/tb_mem_unit_tip.sv
// tb_mem_unit_tip: directed and random stimulus checked against a memory-map reference model
module tb_mem_unit_tip;
  logic clk = 0, reset_bar = 0;
  logic [10:0] addr = '0;
  logic [15:0] in_data = '0, wreg = '0, peri_rdata = '0;
  logic write_enable = 0, read_enable = 0, carry_in = 0, zero_in = 0, peri_irq = 0;
  logic carry_out, zero_out, interrupt, peri_we, peri_re;
  logic [15:0] out_data, peri_wdata;
  logic [7:0] peri_addr;
  int n_tests = 0, n_fail = 0;
  logic [15:0] m_mem [512];
  int m_ptr [2];
  int m_mode;
  bit m_carry, m_zero, m_en, m_pend, m_prev;
  logic [15:0] exp5;

  mem_unit_tip dut (
    .clk(clk), .reset_bar(reset_bar), .addr(addr), .in_data(in_data),
    .write_enable(write_enable), .read_enable(read_enable), .wreg(wreg),
    .carry_in(carry_in), .zero_in(zero_in), .carry_out(carry_out), .zero_out(zero_out),
    .out_data(out_data), .interrupt(interrupt), .peri_addr(peri_addr),
    .peri_wdata(peri_wdata), .peri_rdata(peri_rdata), .peri_we(peri_we),
    .peri_re(peri_re), .peri_irq(peri_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr[0] = 0;
    m_ptr[1] = 0;
    m_mode = 0;
    m_carry = 0;
    m_zero = 0;
    m_en = 0;
    m_pend = 0;
    m_prev = 0;
  endtask

  function automatic logic [15:0] model_rd(input int a);
    if (a < 512) return m_mem[a];
    if (a >= 'h300 && a < 'h400) return peri_rdata;
    case (a - 'h200)
      0: return wreg;
      1: return 16'(m_carry);
      2: return 16'(m_zero);
      3: return 16'({m_pend, m_en, peri_irq});
      4: return m_mem[m_ptr[0]];
      5: return 16'(m_ptr[0]);
      6: return m_mem[m_ptr[1]];
      7: return 16'(m_ptr[1]);
      8: return 16'(m_mode);
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic model_edge(input int a, input logic [15:0] d, input bit we, input bit re);
    int o = a - 'h200;
    bit rise = peri_irq && !m_prev;
    bit clr = 0;
    if (we) begin
      if (a < 512) m_mem[a] = d;
      for (int k = 0; k < 2; k++) begin
        if (o == 4 + 2 * k) m_mem[m_ptr[k]] = d;
        if (o == 5 + 2 * k) m_ptr[k] = d % 512;
      end
      if (o == 8) m_mode = d % 4;
      if (o == 3) begin
        m_en = d[1];
        clr = d[2];
      end
    end
    for (int k = 0; k < 2; k++)
      if ((we || re) && o == 4 + 2 * k && ((m_mode >> k) & 1) == 1) m_ptr[k] = (m_ptr[k] + 1) % 512;
    m_pend = rise ? 1'b1 : clr ? 1'b0 : m_pend;
    m_carry = (we && o == 1) ? d[0] : carry_in;
    m_zero = (we && o == 2) ? d[0] : zero_in;
    m_prev = peri_irq;
  endtask

  task automatic op(input int a, input logic [15:0] d, input bit we, input bit re, input bit ck = 1);
    logic [15:0] exp;
    bit inp = a >= 'h300 && a < 'h400;
    addr = 11'(a);
    in_data = d;
    write_enable = we;
    read_enable = re;
    peri_rdata = 16'($urandom);
    #1;
    chk("peri_we", 16'(peri_we), 16'(we && inp));
    chk("peri_re", 16'(peri_re), 16'(re && inp));
    chk("peri_addr", 16'(peri_addr), 16'((a - 'h300) & 'hFF));
    chk("peri_wdata", peri_wdata, d);
    exp = model_rd(a);
    @(posedge clk);
    model_edge(a, d, we, re);
    #1;
    if (ck) chk("out_data", out_data, exp);
    chk("carry_out", 16'(carry_out), 16'(m_carry));
    chk("zero_out", 16'(zero_out), 16'(m_zero));
    chk("interrupt", 16'(interrupt), 16'(m_en && m_pend));
    write_enable = 0;
    read_enable = 0;
  endtask

  initial begin
    int a;
    wreg = 16'hA5C3;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out_data, 16'h0000);
    chk("rst_carry", 16'(carry_out), 16'h0);
    chk("rst_zero", 16'(zero_out), 16'h0);
    chk("rst_irq", 16'(interrupt), 16'h0);
    reset_bar = 1;
    for (int i = 0; i < 512; i++) op(i, 16'($urandom), 1, 0, 0);
    op('h010, 16'h1234, 1, 0);
    op('h010, 0, 0, 1);
    chk("ram_rd", out_data, 16'h1234);
    op('h2FF, 0, 0, 1);
    chk("unmapped", out_data, 16'hDEAD);
    op('h200, 0, 0, 1);
    chk("wreg_rd", out_data, 16'hA5C3);
    op('h205, 16'h01FF, 1, 0);
    op('h208, 16'h0001, 1, 0);
    op('h204, 16'hAAAA, 1, 0);
    op('h204, 16'hBBBB, 1, 0);
    op('h204, 16'hCCCC, 1, 0);
    op('h1FF, 0, 0, 1);
    chk("inc_a", out_data, 16'hAAAA);
    op('h000, 0, 0, 1);
    chk("inc_wrap", out_data, 16'hBBBB);
    op('h001, 0, 0, 1);
    chk("inc_c", out_data, 16'hCCCC);
    op('h205, 0, 0, 1);
    chk("inc_ptr", out_data, 16'h0002);
    op('h205, 16'h0005, 1, 0);
    op('h208, 16'h0000, 1, 0);
    exp5 = m_mem[5];
    repeat (4) begin
      op('h204, 0, 0, 1);
      chk("ind_hold", out_data, exp5);
    end
    op('h205, 0, 0, 1);
    chk("ptr_hold", out_data, 16'h0005);
    op('h207, 16'hFFFF, 1, 0);
    op('h207, 0, 0, 1);
    chk("ptr_mask", out_data, 16'h01FF);
    carry_in = 0;
    op('h201, 16'h0001, 1, 0);
    chk("carry_wr", 16'(carry_out), 16'h1);
    op('h010, 0, 0, 0);
    chk("carry_in", 16'(carry_out), 16'h0);
    zero_in = 1;
    op('h202, 16'h0000, 1, 0);
    chk("zero_wr", 16'(zero_out), 16'h0);
    op('h010, 0, 0, 0);
    chk("zero_in", 16'(zero_out), 16'h1);
    zero_in = 0;
    op('h203, 16'h0002, 1, 0);
    peri_irq = 1;
    op('h010, 0, 0, 0);
    peri_irq = 0;
    op('h010, 0, 0, 0);
    chk("irq_set", 16'(interrupt), 16'h1);
    op('h010, 0, 0, 0);
    peri_irq = 1;
    op('h203, 16'h0006, 1, 0);
    chk("irq_set_wins", 16'(interrupt), 16'h1);
    op('h203, 16'h0006, 1, 0);
    chk("irq_w1c", 16'(interrupt), 16'h0);
    op('h203, 0, 0, 1);
    chk("irq_reg", out_data, 16'h0003);
    peri_irq = 0;
    op('h345, 16'h7777, 1, 0);
    op('h3FF, 0, 0, 1);
    op('h100, 16'h4444, 1, 1);
    op('h205, 16'h0042, 1, 0);
    op('h207, 16'h0042, 1, 0);
    op('h206, 16'h5A5A, 1, 0);
    op('h204, 0, 0, 1);
    chk("coherent", out_data, 16'h5A5A);
    repeat (400) begin
      case ($urandom_range(0, 3))
        0: a = int'($urandom_range(0, 511));
        1: a = 'h200 + int'($urandom_range(0, 9));
        2: a = 'h300 + int'($urandom_range(0, 255));
        default: a = $urandom_range(0, 1) ? int'($urandom_range('h209, 'h2FF)) : int'($urandom_range('h400, 'h7FF));
      endcase
      carry_in = 1'($urandom);
      zero_in = 1'($urandom);
      peri_irq = 1'($urandom);
      op(a, 16'($urandom), 1'($urandom), 1'($urandom));
    end
    peri_irq = 1;
    op('h203, 16'h0002, 1, 0);
    peri_irq = 0;
    carry_in = 1;
    op('h208, 16'h0001, 1, 0);
    op('h205, 16'h000A, 1, 0);
    op('h207, 16'h0030, 1, 0);
    op('h204, 16'h1111, 1, 0);
    op('h204, 16'h2222, 1, 0);
    addr = 11'h204;
    in_data = 16'h3333;
    write_enable = 1;
    #2;
    reset_bar = 0;
    #1;
    chk("async_out", out_data, 16'h0000);
    chk("async_irq", 16'(interrupt), 16'h0);
    chk("async_carry", 16'(carry_out), 16'h0);
    write_enable = 0;
    carry_in = 0;
    reset_bar = 1;
    model_reset();
    op('h205, 0, 0, 1);
    chk("rst_ptr0", out_data, 16'h0000);
    op('h207, 0, 0, 1);
    chk("rst_ptr1", out_data, 16'h0000);
    op('h208, 0, 0, 1);
    chk("rst_mode", out_data, 16'h0000);
    op('h00A, 0, 0, 1);
    chk("ram_kept0", out_data, 16'h1111);
    op('h00B, 0, 0, 1);
    chk("ram_kept1", out_data, 16'h2222);
    op('h00C, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
